// File: rtl/cam_pkg.sv
// Shared types, constants and the RGB565 -> RGB332 conversion for the camera capture path.
package cam_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } cam_state_e;

   localparam int SCREEN_WIDTH  = 176;
   localparam int SCREEN_HEIGHT = 144;

   localparam logic [7:0] RGB332_BLACK = 8'h00;
   localparam logic [7:0] RGB332_RED   = 8'hE0;
   localparam logic [7:0] RGB332_GREEN = 8'h1C;
   localparam logic [7:0] RGB332_BLUE  = 8'h03;
   localparam logic [7:0] RGB332_WHITE = 8'hFF;

   // Keeps the top bits of each channel: R[4:2], G[5:3], B[4:3].
   function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
      logic [15:0] px;
      px = {hi, lo};
      return {px[15:13], px[10:8], px[4:3]};
   endfunction

endpackage

// File: rtl/cam_rgb_pack.sv
// Pairs camera bytes into RGB565 pixels and emits a registered RGB332 word with its write strobe.
module cam_rgb_pack
   import cam_pkg::*;
(
   input  logic       CLOCK,
   input  logic       RESET_N,
   input  logic       byte_en,
   input  logic       clr,
   input  logic       keep,
   input  logic [7:0] cam_data,
   output logic       phase,
   output logic       pix_fire,
   output logic [7:0] pix_data,
   output logic       pix_valid
);

   logic [7:0] hi_byte;

   // A clear (line advance or frame start) always wins over a byte in the same cycle.
   assign pix_fire = byte_en & phase & ~clr;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         phase     <= 1'b0;
         hi_byte   <= 8'h00;
         pix_data  <= 8'h00;
         pix_valid <= 1'b0;
      end else begin
         pix_valid <= pix_fire & keep;
         if (pix_fire && keep)
            pix_data <= rgb565_to_332(hi_byte, cam_data);

         if (clr) begin
            phase <= 1'b0;
         end else if (byte_en) begin
            phase <= ~phase;
            if (!phase)
               hi_byte <= cam_data;
         end
      end
   end

endmodule

// File: rtl/cam_capture_ctrl.sv
// Camera-to-frame-buffer write sequencer: armed/capture/done FSM, line/pixel counters, write port.
// Optional FRAME_DBL_BUF_EN adds W_BANK/DISP_BANK ping-pong bank outputs.
module cam_capture_ctrl
   import cam_pkg::*;
#(
   parameter int WIDTH  = SCREEN_WIDTH,
   parameter int HEIGHT = SCREEN_HEIGHT,
   parameter int ADDR_W = 15
) (
   input  logic              CLOCK,
   input  logic              RESET_N,
   input  logic              CAM_VSYNC,
   input  logic              CAM_HREF,
   input  logic [7:0]        CAM_DATA,
   input  logic              CAPTURE_REQ,
   input  logic              CONTINUOUS,
   output logic [ADDR_W-1:0] W_ADDR,
   output logic [7:0]        W_DATA,
   output logic              W_EN,
   output logic              BUSY,
   output logic              FRAME_DONE,
   output logic              LINE_ERR,
`ifdef FRAME_DBL_BUF_EN
   output logic              W_BANK,
   output logic              DISP_BANK,
`endif
   output logic              FRAME_ERR
);

   localparam int XW = $clog2(WIDTH + 1);
   localparam int YW = $clog2(HEIGHT + 1);

   cam_state_e        state, state_nx;
   logic              prev_vsync, prev_href;
   logic [XW-1:0]     x;
   logic [YW-1:0]     y;
   logic [ADDR_W-1:0] line_base;
   logic              x_ovf, line_has_byte;

   logic vsync_rise, href_fall, in_capture;
   logic frame_start, short_frame, line_adv, last_line;
   logic byte_en, x_full, phase, pix_fire;

   assign vsync_rise  = CAM_VSYNC & ~prev_vsync;
   assign href_fall   = ~CAM_HREF & prev_href;
   assign in_capture  = (state == CAPTURE);

   // Event priority: VSYNC rise, then HREF fall, then byte sampling.
   assign frame_start = vsync_rise & ((state == ARMED) | in_capture);
   assign short_frame = vsync_rise & in_capture;
   assign line_adv    = in_capture & ~vsync_rise & href_fall & line_has_byte;
   assign last_line   = line_adv & (y == YW'(HEIGHT - 1));
   assign byte_en     = in_capture & ~vsync_rise & CAM_HREF;
   assign x_full      = (x == XW'(WIDTH));

   cam_rgb_pack u_pack (
      .CLOCK     (CLOCK),
      .RESET_N   (RESET_N),
      .byte_en   (byte_en),
      .clr       (frame_start | line_adv),
      .keep      (~x_full),
      .cam_data  (CAM_DATA),
      .phase     (phase),
      .pix_fire  (pix_fire),
      .pix_data  (W_DATA),
      .pix_valid (W_EN)
   );

   // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (CAPTURE_REQ) state_nx = ARMED;
         ARMED:   if (vsync_rise)  state_nx = CAPTURE;
         CAPTURE: if (last_line)   state_nx = DONE;
         DONE:    state_nx = CONTINUOUS ? ARMED : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= IDLE;
         prev_vsync <= 1'b0;
         prev_href  <= 1'b0;
         BUSY       <= 1'b0;
         FRAME_DONE <= 1'b0;
      end else begin
         state      <= state_nx;
         prev_vsync <= CAM_VSYNC;
         prev_href  <= CAM_HREF;
         BUSY       <= (state_nx != IDLE);
         FRAME_DONE <= (state_nx == DONE);
      end
   end

   // Line base accumulates WIDTH per line so the address needs only an adder.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         x             <= '0;
         y             <= '0;
         line_base     <= '0;
         x_ovf         <= 1'b0;
         line_has_byte <= 1'b0;
         W_ADDR        <= '0;
      end else begin
         if (frame_start) begin
            x             <= '0;
            y             <= '0;
            line_base     <= '0;
            x_ovf         <= 1'b0;
            line_has_byte <= 1'b0;
         end else if (line_adv) begin
            x             <= '0;
            y             <= y + 1'b1;
            line_base     <= line_base + ADDR_W'(WIDTH);
            x_ovf         <= 1'b0;
            line_has_byte <= 1'b0;
         end else if (byte_en) begin
            line_has_byte <= 1'b1;
            if (pix_fire) begin
               if (x_full) begin
                  x_ovf <= 1'b1;
               end else begin
                  x      <= x + 1'b1;
                  W_ADDR <= line_base + ADDR_W'(x);
               end
            end
         end
      end
   end

   // A line is bad if it ran short, ran long (saturated and kept going) or ended on an odd byte.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         LINE_ERR  <= 1'b0;
         FRAME_ERR <= 1'b0;
      end else begin
         if (frame_start)
            LINE_ERR <= 1'b0;
         else if (line_adv && (!x_full || x_ovf || phase))
            LINE_ERR <= 1'b1;

         if (state == IDLE && CAPTURE_REQ)
            FRAME_ERR <= 1'b0;
         else if (short_frame)
            FRAME_ERR <= 1'b1;
      end
   end

`ifdef FRAME_DBL_BUF_EN
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         W_BANK    <= 1'b0;
         DISP_BANK <= 1'b0;
      end else if (state == DONE) begin
         DISP_BANK <= W_BANK;
         W_BANK    <= ~W_BANK;
      end
   end
`endif

endmodule
